// File: rtl/display_pkg.sv
// display_pkg
// Shared definitions for the multiplexed 7-segment display scanner:
//   - segment patterns (bit0 = a ... bit6 = g, active high)
//   - scan FSM state encoding
//   - slot-length helper and parameter legality check
package display_pkg;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  // ST_IDLE only exists between reset release and the first edge, so that
  // edge can take the snapshot and open slot 0 of digit 0.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEAD,
    ST_ON
  } scan_state_t;

  function automatic int ticks_per_slot(input int clock_hz, input int refresh_hz);
    return clock_hz / refresh_hz;
  endfunction

  function automatic bit params_legal(input int ticks, input int digits,
                                      input int dead_cycles);
    return (digits >= 1) && (digits <= 8) && (dead_cycles >= 1) &&
           (ticks >= dead_cycles + 2);
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7
// Combinational nibble to 7-segment decoder. 0-9 map to their digit
// patterns; A-F are not BCD and are shown as a dash.
// Ports:
//   nibble  in  4  BCD digit
//   seg     out 7  segment pattern, bit0 = a ... bit6 = g
module bcd_to_seg7
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/display_scan_controller.sv
// display_scan_controller
// Time-multiplexes one segment bus across DIGITS common-cathode digits.
// A packed BCD word and dot mask are snapshotted once per frame; each digit
// slot is TICKS cycles, starting with DEAD_CYCLES of all cathodes off so the
// segment bus can change without ghosting into the neighbouring digit.
// Ports:
//   Clock         in   1         system clock, rising edge
//   Reset         in   1         asynchronous, active-low reset
//   Bcd_i         in   4*DIGITS  packed BCD, nibble 0 = units
//   Dots_i        in   DIGITS    decimal point request per digit
//   Cathodes_o    out  DIGITS    active-low one-cold digit enable
//   Segments_o    out  8         active-high, bit7 = dp
//   FrameStart_o  out  1         pulse in the cycle the snapshot is taken
module display_scan_controller
  import display_pkg::*;
#(
  parameter int CLOCK_HZ    = 1_000_000,
  parameter int REFRESH_HZ  = 1_000,
  parameter int DIGITS      = 4,
  parameter int DEAD_CYCLES = 2,
  parameter int BLANK_ZEROS = 1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [4*DIGITS-1:0]   Bcd_i,
  input  logic [DIGITS-1:0]     Dots_i,
  output logic [DIGITS-1:0]     Cathodes_o,
  output logic [7:0]            Segments_o,
  output logic                  FrameStart_o
);

  localparam int TICKS = ticks_per_slot(CLOCK_HZ, REFRESH_HZ);
  localparam int SW    = $clog2(TICKS);
  localparam int DW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [SW-1:0] S_LAST      = SW'(TICKS - 1);
  localparam logic [SW-1:0] S_DEAD_LAST = SW'(DEAD_CYCLES - 1);
  localparam logic [DW-1:0] D_LAST      = DW'(DIGITS - 1);

  if (!params_legal(TICKS, DIGITS, DEAD_CYCLES)) begin : g_bad_params
    $error("display_scan_controller: illegal TICKS/DIGITS/DEAD_CYCLES");
  end

  scan_state_t           state;
  logic [SW-1:0]         s;
  logic [DW-1:0]         d;
  logic [4*DIGITS-1:0]   bcd_q;
  logic [DIGITS-1:0]     dots_q;

  logic                  slot_entry;
  logic                  frame_start;
  logic [DW-1:0]         d_up;
  logic [4*DIGITS-1:0]   src_bcd;
  logic [DIGITS-1:0]     src_dots;
  logic [3:0]            nibble_up;
  logic [6:0]            seg_up;
  logic [DIGITS-1:0]     blank;
  logic                  lead_zero;

  // Edge about to open a new slot, and whether that slot is digit 0.
  assign slot_entry  = (state == ST_IDLE) || (state == ST_ON && s == S_LAST);
  assign frame_start = (state == ST_IDLE) ||
                       (state == ST_ON && s == S_LAST && d == D_LAST);
  assign d_up        = (state == ST_IDLE || d == D_LAST) ? '0 : d + 1'b1;

  // On the snapshot edge bcd_q still holds the old frame, so the first
  // slot's pattern must be decoded straight from the inputs.
  assign src_bcd  = frame_start ? Bcd_i  : bcd_q;
  assign src_dots = frame_start ? Dots_i : dots_q;

  // NOTE: combinational blocks assign a default to every output first, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    nibble_up = src_bcd[4*int'(d_up) +: 4];
    blank     = '0;
    lead_zero = 1'b1;
    // Walk down from the most significant digit; a digit is blanked only
    // while everything above and including it is zero with no dot.
    for (int k = DIGITS - 1; k >= 1; k--) begin
      lead_zero = lead_zero && (src_bcd[4*k +: 4] == 4'd0) && !src_dots[k];
      blank[k]  = lead_zero && (BLANK_ZEROS != 0);
    end
  end

  bcd_to_seg7 u_dec (
    .nibble (nibble_up),
    .seg    (seg_up)
  );

  // NOTE: the snapshot registers are reset along with the control state so
  // the first frame after reset never displays stale data.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state        <= ST_IDLE;
      s            <= '0;
      d            <= '0;
      bcd_q        <= '0;
      dots_q       <= '0;
      Cathodes_o   <= '1;
      Segments_o   <= '0;
      FrameStart_o <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      FrameStart_o <= frame_start;
      if (frame_start) begin
        bcd_q  <= Bcd_i;
        dots_q <= Dots_i;
      end
      // Segments change only on slot entry, when the cathodes go all-off.
      if (slot_entry) begin
        Segments_o <= {src_dots[d_up], blank[d_up] ? SEG_OFF : seg_up};
      end
      case (state)
        ST_IDLE: begin
          s          <= '0;
          d          <= '0;
          state      <= ST_DEAD;
          Cathodes_o <= '1;
        end
        ST_DEAD: begin
          s <= s + 1'b1;
          if (s == S_DEAD_LAST) begin
            state      <= ST_ON;
            Cathodes_o <= ~(DIGITS'(1) << d);
          end
        end
        ST_ON: begin
          if (s == S_LAST) begin
            s          <= '0;
            d          <= d_up;
            state      <= ST_DEAD;
            Cathodes_o <= '1;
          end else begin
            s <= s + 1'b1;
          end
        end
        default: begin
          state      <= ST_IDLE;
          Cathodes_o <= '1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller with TICKS = 10, DIGITS = 4,
// DEAD_CYCLES = 2. Each vector resets the DUT, releases it and checks every
// cycle of one frame against hand-computed segment patterns.
module tb_display_scan_controller;

  localparam int DIGITS = 4;
  localparam int TICKS  = 10;
  localparam int DEAD   = 2;
  localparam int FRAME  = DIGITS * TICKS;

  logic                Clock;
  logic                Reset;
  logic [15:0]         Bcd_i;
  logic [3:0]          Dots_i;
  logic [3:0]          Cathodes_o;
  logic [7:0]          Segments_o;
  logic                FrameStart_o;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    string             name;
    logic [15:0]       bcd;
    logic [3:0]        dots;
    logic [3:0][7:0]   segs;   // {digit3, digit2, digit1, digit0}
  } vec_t;

  vec_t vecs[9];

  display_scan_controller #(
    .CLOCK_HZ    (1_000_000),
    .REFRESH_HZ  (100_000),
    .DIGITS      (DIGITS),
    .DEAD_CYCLES (DEAD),
    .BLANK_ZEROS (1)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .Bcd_i        (Bcd_i),
    .Dots_i       (Dots_i),
    .Cathodes_o   (Cathodes_o),
    .Segments_o   (Segments_o),
    .FrameStart_o (FrameStart_o)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  // Cycle c counts from the first edge after reset release.
  task automatic expect_cycle(input int c, input logic [3:0][7:0] segs,
                              input string tag);
    int         p;
    int         k;
    int         s;
    logic [3:0] cath_exp;
    p = c % FRAME;
    k = p / TICKS;
    s = p % TICKS;
    cath_exp = (s < DEAD) ? 4'hF : (4'hF ^ (4'b0001 << k));
    check($sformatf("%s c%0d cathodes", tag, c), {4'h0, Cathodes_o}, {4'h0, cath_exp});
    check($sformatf("%s c%0d segments", tag, c), Segments_o, segs[k]);
    check($sformatf("%s c%0d framestart", tag, c), {7'h0, FrameStart_o},
          {7'h0, (p == 0)});
  endtask

  task automatic check_reset_outputs(input string tag);
    check($sformatf("%s cathodes", tag), {4'h0, Cathodes_o}, 8'h0F);
    check($sformatf("%s segments", tag), Segments_o, 8'h00);
    check($sformatf("%s framestart", tag), {7'h0, FrameStart_o}, 8'h00);
  endtask

  // Reset, load inputs, release; cycle 0 is sampled at the next negedge.
  task automatic restart(input logic [15:0] bcd, input logic [3:0] dots);
    @(negedge Clock);
    Reset  = 1'b0;
    Bcd_i  = bcd;
    Dots_i = dots;
    @(negedge Clock);
    Reset = 1'b1;
  endtask

  initial begin
    logic [3:0][7:0] seg_1234;
    logic [3:0][7:0] seg_9876;
    logic [3:0][7:0] seg_0007;

    seg_1234 = {8'h06, 8'h5B, 8'h4F, 8'h66};
    seg_9876 = {8'h6F, 8'h7F, 8'h07, 8'h7D};
    seg_0007 = {8'h00, 8'h00, 8'h00, 8'h07};

    vecs[0] = '{"scan_1234",   16'h1234, 4'b0000, seg_1234};
    vecs[1] = '{"lz_0007",     16'h0007, 4'b0000, seg_0007};
    vecs[2] = '{"lz_0000",     16'h0000, 4'b0000, {8'h00, 8'h00, 8'h00, 8'h3F}};
    vecs[3] = '{"lz_dot2",     16'h0007, 4'b0100, {8'h00, 8'hBF, 8'h3F, 8'h07}};
    vecs[4] = '{"invalid_a5",  16'h00A5, 4'b0000, {8'h00, 8'h00, 8'h40, 8'h6D}};
    vecs[5] = '{"scan_9876",   16'h9876, 4'b0000, seg_9876};
    vecs[6] = '{"zero_dot0",   16'h0000, 4'b0001, {8'h00, 8'h00, 8'h00, 8'hBF}};
    vecs[7] = '{"inner_zeros", 16'h1000, 4'b0000, {8'h06, 8'h3F, 8'h3F, 8'h3F}};
    vecs[8] = '{"dash_top",    16'hF000, 4'b0000, {8'h40, 8'h3F, 8'h3F, 8'h3F}};

    Reset  = 1'b1;
    Bcd_i  = 16'h1234;
    Dots_i = 4'b0000;
    #3 Reset = 1'b0;

    // Reset held low across several edges.
    repeat (3) @(negedge Clock);
    check_reset_outputs("reset_hold");

    // Table-driven single frames.
    foreach (vecs[i]) begin
      restart(vecs[i].bcd, vecs[i].dots);
      for (int c = 0; c < FRAME; c++) begin
        @(negedge Clock);
        expect_cycle(c, vecs[i].segs, vecs[i].name);
      end
    end

    // Anti-tearing: input changes mid-frame show only from the next frame;
    // also checks the FrameStart_o period.
    restart(16'h1234, 4'b0000);
    for (int c = 0; c < 2 * FRAME; c++) begin
      @(negedge Clock);
      expect_cycle(c, (c < FRAME) ? seg_1234 : seg_9876, "tear");
      if (c == 15) Bcd_i = 16'h9876;
    end
    @(negedge Clock);
    check("tear third framestart", {7'h0, FrameStart_o}, 8'h01);

    // Asynchronous reset mid-frame, between clock edges.
    restart(16'h0007, 4'b0000);
    for (int c = 0; c <= 17; c++) begin
      @(negedge Clock);
      expect_cycle(c, seg_0007, "midrst");
    end
    #2 Reset = 1'b0;
    #1 check_reset_outputs("midrst async");
    @(posedge Clock);
    #1 check_reset_outputs("midrst held");
    @(negedge Clock);
    Bcd_i = 16'h1234;
    Reset = 1'b1;
    for (int c = 0; c < FRAME; c++) begin
      @(negedge Clock);
      expect_cycle(c, seg_1234, "after_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
